imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Two-stage pipelined immediate generator with a valid/ready handshake. It turns a raw instruction immediate field into a full-width datapath operand. It handles 16-, 21- and 26-bit sign extension, zero extension, upper-immediate, branch-target and jump-target modes. It sits between instruction decode and the execute-stage operand mux, and replaces the single-purpose combinational extenders with one parametrised, stallable unit.

## Interface
Parameters:
- IMM_W, 26, width of the raw immediate field; must be ≥ 26.
- DATA_W, 32, width of operand and PC; must be ≥ IMM_W + 2.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents a request.
- in_ready  out  1  unit accepts a request this cycle (combinational).
- in_imm  in  IMM_W  raw immediate bits, LSB-aligned.
- in_mode  in  3  extension mode (see Operation).
- in_pc  in  DATA_W  address of the instruction.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  extended operand or target address.
- out_err  out  1  request carried a reserved mode.

## Operation
Modes (in_mode). f16 = in_imm[15:0], f21 = in_imm[20:0], f26 = in_imm[25:0]:
- 000 ZERO16: zero-extend f16.
- 001 SIGN16: sign-extend f16 from bit 15.
- 010 SIGN21: sign-extend f21 from bit 20.
- 011 SIGN26: sign-extend f26 from bit 25.
- 100 UPPER16: {f16, 16'b0}, zero-filled above bit 31 when DATA_W > 32.
- 101 BRANCH: in_pc + 4 + (sext(f16) << 2), modulo 2^DATA_W; no overflow flag.
- 110 JUMP: {pc_plus4[DATA_W-1:IMM_W+2], f26, 2'b00}, where pc_plus4 = in_pc + 4. Bits of in_imm above 25 are ignored.
- 111 reserved: out_data = 0, out_err = 1.
- out_err = 0 for all non-reserved modes.

Stage 1 (S1), registered on acceptance:
- Holds the extended value ext. For BRANCH, ext = sext(f16) << 2.
- Holds pc_plus4, the mode, and the err bit.

Stage 2 (S2):
- Registers the final result. For BRANCH this is pc_plus4 + ext.
- For JUMP it is the concatenation above.
- For all other modes it is ext.

Handshake rules:
- Each stage has a valid bit, s1_v and s2_v.
- s2_adv = !s2_v || out_ready.
- s1_adv = !s1_v || s2_adv.
- in_ready = s1_adv.
- Transfer at an edge occurs when in_valid && in_ready.
- S2 loads from S1 when s1_v && s2_adv.
- s2_v is cleared when out_ready && !(s1_v).
- Simultaneous events: a new input and an S1→S2 move happen in the same edge when the pipeline is moving. Full throughput is one request per cycle.
- Stall: while out_valid && !out_ready, out_data and out_err hold bit-stable. S1 holds if it is occupied. in_ready = 0 only when both stages are full and out_ready = 0.
- Inputs are sampled only on transfer. Changing in_* while in_ready = 0 has no effect.

## Timing
- Reset (sampled at an edge while reset = 1):
  - s1_v = 0, s2_v = 0, out_valid = 0, out_data = 0, out_err = 0.
  - in_ready = 1 from the cycle after reset deasserts. It is also 1 during reset, but transfers during reset are discarded.
- Reset mid-operation: all in-flight requests are dropped without producing output. Reset has priority over every transfer in the same edge.
- Latency: request accepted at edge k → out_valid = 1 and out_data valid during the cycle following edge k+1, assuming no stall.
- Back-to-back: with out_ready held high, requests accepted at edges k, k+1, k+2 appear on consecutive cycles after edges k+1, k+2, k+3.
- Wrap-around: the BRANCH/JUMP pc+4 and target addition wrap modulo 2^DATA_W. Example: in_pc = 32'hFFFF_FFFC gives pc_plus4 = 0.
- out_valid, out_data and out_err are driven directly from S2 registers, with no combinational path from in_*. in_ready depends combinationally on out_ready only.

## Test plan
- SIGN16 0x8000 and ZERO16 0x8000, back-to-back with out_ready = 1 → out_data 32'hFFFF_8000 then 32'h0000_8000 on consecutive cycles, each 2 edges after acceptance.
- SIGN26 imm 26'h200_0001, SIGN21 imm 21'h10_0000, UPPER16 imm 16'h1234 → 32'hFE00_0001, 32'hFFF0_0000, 32'h1234_0000.
- BRANCH pc 32'h0040_0010, f16 = 16'hFFFF → 32'h0040_0010; JUMP pc 32'hA000_0000, f26 = 26'h000_0040 → 32'hA000_0100; BRANCH pc 32'hFFFF_FFFC, f16 = 0 → 32'h0000_0000.
- Mode 111 → out_data 0, out_err 1; the next request (mode 000) has out_err 0.
- Backpressure: 4 requests with out_ready = 0 → in_ready drops after the 2nd acceptance and out_data holds stable. Raise out_ready → all 4 results delivered in order with no loss or duplication.
- Reset asserted for one edge with both stages full → out_valid 0 and out_data 0 the next cycle; the dropped requests never appear on the output.

Source files
------------

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Purpose  : Two-stage stallable immediate generator. It turns a raw
//            instruction immediate into a full-width operand or a
//            branch/jump target. Uses a valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
  parameter int IMM_W  = 26,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  // Extension modes
  localparam logic [2:0] c_ZERO16  = 3'b000;
  localparam logic [2:0] c_SIGN16  = 3'b001;
  localparam logic [2:0] c_SIGN21  = 3'b010;
  localparam logic [2:0] c_SIGN26  = 3'b011;
  localparam logic [2:0] c_UPPER16 = 3'b100;
  localparam logic [2:0] c_BRANCH  = 3'b101;
  localparam logic [2:0] c_JUMP    = 3'b110;

  // A jump target keeps only the pc_plus4 bits above the shifted 26-bit field
  localparam logic [DATA_W-1:0] c_JMASK = {DATA_W{1'b1}} << (IMM_W + 2);

  // Stage registers
  logic              r_s1_v;
  logic [DATA_W-1:0] r_s1_ext;
  logic [DATA_W-1:0] r_s1_pc4;
  logic [2:0]        r_s1_mode;
  logic              r_s1_err;
  logic              r_s2_v;
  logic [DATA_W-1:0] r_s2_data;
  logic              r_s2_err;

  // Combinational helpers
  logic              w_s1_adv;
  logic              w_s2_adv;
  logic [15:0]       w_f16;
  logic [20:0]       w_f21;
  logic [25:0]       w_f26;
  logic [DATA_W-1:0] w_sext16;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_pc4;
  logic [DATA_W-1:0] w_s2_res;

  assign w_f16 = in_imm[15:0];
  assign w_f21 = in_imm[20:0];
  assign w_f26 = in_imm[25:0];

  assign w_sext16 = {{(DATA_W-16){w_f16[15]}}, w_f16};
  assign w_pc4    = in_pc + DATA_W'(4);

  // A stage may take new contents when it is empty or the next one drains it
  assign w_s2_adv = !r_s2_v || out_ready;
  assign w_s1_adv = !r_s1_v || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Stage-1 extension. JUMP carries its shifted field here and merges PC bits later.
  always_comb begin
    w_ext = '0;
    case (in_mode)
      c_ZERO16:  w_ext = {{(DATA_W-16){1'b0}}, w_f16};
      c_SIGN16:  w_ext = w_sext16;
      c_SIGN21:  w_ext = {{(DATA_W-21){w_f21[20]}}, w_f21};
      c_SIGN26:  w_ext = {{(DATA_W-26){w_f26[25]}}, w_f26};
      c_UPPER16: w_ext = DATA_W'({w_f16, 16'h0000});
      c_BRANCH:  w_ext = w_sext16 << 2;
      c_JUMP:    w_ext = DATA_W'({w_f26, 2'b00});
      default:   w_ext = '0;
    endcase
  end

  // Stage-2 result: the target arithmetic is finished here, wrapping modulo 2^DATA_W
  always_comb begin
    w_s2_res = r_s1_ext;
    case (r_s1_mode)
      c_BRANCH: w_s2_res = r_s1_pc4 + r_s1_ext;
      c_JUMP:   w_s2_res = (r_s1_pc4 & c_JMASK) | r_s1_ext;
      default:  w_s2_res = r_s1_ext;
    endcase
  end

  // Pipeline registers. Reset drops everything in flight and wins over transfers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_v    <= 1'b0;
      r_s1_ext  <= '0;
      r_s1_pc4  <= '0;
      r_s1_mode <= 3'b000;
      r_s1_err  <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s2_data <= '0;
      r_s2_err  <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_v <= in_valid;
        if (in_valid) begin
          r_s1_ext  <= w_ext;
          r_s1_pc4  <= w_pc4;
          r_s1_mode <= in_mode;
          r_s1_err  <= (in_mode == 3'b111);
        end
      end
      if (w_s2_adv) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_s2_data <= w_s2_res;
          r_s2_err  <= r_s1_err;
        end
      end
    end
  end

  assign out_valid = r_s2_v;
  assign out_data  = r_s2_data;
  assign out_err   = r_s2_err;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_pipe
// Purpose  : Directed self-checking bench for imm_extend_pipe
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

  localparam int IMM_W  = 26;
  localparam int DATA_W = 32;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  in_imm;
  logic [2:0]        in_mode;
  logic [DATA_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  int n_tests = 0;
  int n_fail  = 0;

  imm_extend_pipe #(.IMM_W(IMM_W), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] mode, input logic [25:0] imm, input logic [31:0] pc);
    in_valid = 1'b1;
    in_mode  = mode;
    in_imm   = imm;
    in_pc    = pc;
  endtask

  // Single isolated request with out_ready high: result visible after the second edge
  task automatic run_one(input string tag, input logic [2:0] mode, input logic [25:0] imm,
                         input logic [31:0] pc, input logic [31:0] exp_d, input logic exp_e);
    drive(mode, imm, pc);
    step();
    in_valid = 1'b0;
    chk({tag, "_notyet"}, {63'd0, out_valid}, 64'd0);
    step();
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_data"}, {32'd0, out_data}, {32'd0, exp_d});
    chk({tag, "_err"}, {63'd0, out_err}, {63'd0, exp_e});
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 3'b000;
    in_imm    = '0;
    in_pc     = '0;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_err", {63'd0, out_err}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Back-to-back SIGN16 / ZERO16 of 0x8000
    drive(3'b001, 26'h000_8000, 32'h0);
    step();
    drive(3'b000, 26'h000_8000, 32'h0);
    step();
    in_valid = 1'b0;
    chk("b2b_a_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b_a_data", {32'd0, out_data}, 64'h0000_0000_FFFF_8000);
    step();
    chk("b2b_b_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b_b_data", {32'd0, out_data}, 64'h0000_0000_0000_8000);
    step();
    chk("b2b_drain", {63'd0, out_valid}, 64'd0);

    // Extension modes; upper immediate bits set to prove they are ignored
    run_one("sign26", 3'b011, 26'h200_0001, 32'h0, 32'hFE00_0001, 1'b0);
    run_one("sign21", 3'b010, 26'h210_0000, 32'h0, 32'hFFF0_0000, 1'b0);
    run_one("upper16", 3'b100, 26'h3FF_1234, 32'h0, 32'h1234_0000, 1'b0);
    run_one("branch_neg", 3'b101, 26'h000_FFFF, 32'h0040_0010, 32'h0040_0010, 1'b0);
    run_one("branch_fwd", 3'b101, 26'h000_0003, 32'h0000_1000, 32'h0000_1010, 1'b0);
    run_one("jump", 3'b110, 26'h000_0040, 32'hA000_0000, 32'hA000_0100, 1'b0);
    run_one("jump_carry", 3'b110, 26'h3FF_FFFF, 32'h0FFF_FFFC, 32'h1FFF_FFFC, 1'b0);
    run_one("branch_wrap", 3'b101, 26'h000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);
    run_one("reserved", 3'b111, 26'h3FF_FFFF, 32'h1234_5678, 32'h0000_0000, 1'b1);
    run_one("after_rsv", 3'b000, 26'h000_8000, 32'h0, 32'h0000_8000, 1'b0);

    // Backpressure: four requests while downstream is stalled
    out_ready = 1'b0;
    drive(3'b000, 26'h000_0001, 32'h0);
    step();
    chk("bp_rdy_after1", {63'd0, in_ready}, 64'd1);
    drive(3'b000, 26'h000_0002, 32'h0);
    step();
    chk("bp_rdy_after2", {63'd0, in_ready}, 64'd0);
    chk("bp_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_data_r1", {32'd0, out_data}, 64'd1);
    drive(3'b000, 26'h000_0BAD, 32'h0);
    step();
    chk("bp_hold1", {32'd0, out_data}, 64'd1);
    chk("bp_rdy_hold", {63'd0, in_ready}, 64'd0);
    step();
    chk("bp_hold2", {32'd0, out_data}, 64'd1);
    chk("bp_valid_hold", {63'd0, out_valid}, 64'd1);
    drive(3'b000, 26'h000_0003, 32'h0);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_release", {63'd0, in_ready}, 64'd1);
    step();
    chk("bp_data_r2", {32'd0, out_data}, 64'd2);
    drive(3'b000, 26'h000_0004, 32'h0);
    step();
    in_valid = 1'b0;
    chk("bp_data_r3", {32'd0, out_data}, 64'd3);
    step();
    chk("bp_data_r4", {32'd0, out_data}, 64'd4);
    chk("bp_valid_r4", {63'd0, out_valid}, 64'd1);
    step();
    chk("bp_no_dup", {63'd0, out_valid}, 64'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    drive(3'b000, 26'h000_0055, 32'h0);
    step();
    drive(3'b000, 26'h000_0066, 32'h0);
    step();
    in_valid = 1'b0;
    chk("mrst_full", {63'd0, out_valid}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_data", {32'd0, out_data}, 64'd0);
    chk("mrst_err", {63'd0, out_err}, 64'd0);
    out_ready = 1'b1;
    chk("mrst_rdy", {63'd0, in_ready}, 64'd1);
    step();
    chk("mrst_drop1", {63'd0, out_valid}, 64'd0);
    step();
    chk("mrst_drop2", {63'd0, out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
